// File: rtl/char_buf_arbiter.sv
// Write-side owner of the 16x16 character buffer: round-robin arbitration of two
// single-cell writers plus a full-screen clear sequencer, optionally gated to vblank.
module char_buf_arbiter #(
  parameter bit         BLANK_ONLY = 1'b1,
  parameter logic [6:0] CLEAR_CODE = 7'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       clr_done,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic [6:0] code0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic [6:0] code1,
  output logic       ack1,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [6:0] wr_data
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rr_last_q, rr_last_d;
  logic       gnt_q, gnt_d;
  logic [7:0] gaddr_q, gaddr_d;
  logic [6:0] gcode_q, gcode_d;
  logic       fin_q, fin_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [6:0] wr_data_q, wr_data_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic ok;
  logic gnt_sel;

  assign ok      = vblank | ~BLANK_ONLY;
  // With both pending, the requester that did not win last time goes next.
  assign gnt_sel = (req0 & req1) ? ~rr_last_q : req1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    gaddr_d   = gaddr_q;
    gcode_d   = gcode_q;
    fin_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done_d    = fin_q;

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = 8'd0;
        end else if (ok && (req0 || req1)) begin
          state_d = WRITE;
          gnt_d   = gnt_sel;
          gaddr_d = gnt_sel ? addr1 : addr0;
          gcode_d = gnt_sel ? code1 : code0;
        end
      end
      WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = gaddr_q;
        wr_data_d = gcode_q;
        ack0_d    = ~gnt_q;
        ack1_d    = gnt_q;
        rr_last_d = gnt_q;
        state_d   = IDLE;
      end
      CLEAR: begin
        if (ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = CLEAR_CODE;
          if (cnt_q == 8'hFF) begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy stays up through the cycle that shows the final clear write.
    busy_d = (state_d == CLEAR) | fin_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      rr_last_q <= 1'b1;
      gnt_q     <= 1'b0;
      gaddr_q   <= 8'd0;
      gcode_q   <= 7'd0;
      fin_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 7'd0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      gaddr_q   <= gaddr_d;
      gcode_q   <= gcode_d;
      fin_q     <= fin_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Directed bench for char_buf_arbiter: default (blank-gated) instance plus an
// ungated instance for the BLANK_ONLY=0 case.
module tb_char_buf_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vblank = 1'b0;
  logic       clr_req = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = 8'd0, addr1 = 8'd0;
  logic [6:0] code0 = 7'd0, code1 = 7'd0;
  logic       clr_busy, clr_done, ack0, ack1, wr_en;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;

  logic       b_req1 = 1'b0;
  logic [7:0] b_addr1 = 8'd0;
  logic [6:0] b_code1 = 7'd0;
  logic       b_clr_busy, b_clr_done, b_ack0, b_ack1, b_wr_en;
  logic [7:0] b_wr_addr;
  logic [6:0] b_wr_data;
  logic       zero = 1'b0;
  logic [7:0] zero8 = 8'd0;
  logic [6:0] zero7 = 7'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  char_buf_arbiter dut (
    .clk(clk), .rst(rst), .vblank(vblank), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .req0(req0), .addr0(addr0), .code0(code0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .code1(code1), .ack1(ack1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  char_buf_arbiter #(.BLANK_ONLY(1'b0), .CLEAR_CODE(7'h20)) dut_nb (
    .clk(clk), .rst(rst), .vblank(vblank), .clr_req(zero),
    .clr_busy(b_clr_busy), .clr_done(b_clr_done),
    .req0(zero), .addr0(zero8), .code0(zero7), .ack0(b_ack0),
    .req1(b_req1), .addr1(b_addr1), .code1(b_code1), .ack1(b_ack1),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, ".ack0"}, {31'd0, ack0}, 32'd0);
    chk({tag, ".ack1"}, {31'd0, ack1}, 32'd0);
  endtask

  initial begin
    logic seen;
    logic [1:0] rr_exp [8];
    rr_exp[0] = 2'b00; rr_exp[1] = 2'b01; rr_exp[2] = 2'b00; rr_exp[3] = 2'b10;
    rr_exp[4] = 2'b00; rr_exp[5] = 2'b01; rr_exp[6] = 2'b00; rr_exp[7] = 2'b10;

    // Reset state
    tick();
    chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst.wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst.wr_data", {25'd0, wr_data}, 32'd0);
    chk("rst.ack0", {31'd0, ack0}, 32'd0);
    chk("rst.ack1", {31'd0, ack1}, 32'd0);
    chk("rst.busy", {31'd0, clr_busy}, 32'd0);
    chk("rst.done", {31'd0, clr_done}, 32'd0);
    rst = 1'b1;

    // First write: visible two edges after the request
    req0 = 1'b1; addr0 = 8'h23; code0 = 7'h41; vblank = 1'b1;
    tick();
    chk("w0.lat1", {31'd0, wr_en}, 32'd0);
    tick();
    chk("w0.wr_en", {31'd0, wr_en}, 32'd1);
    chk("w0.addr", {24'd0, wr_addr}, 32'h23);
    chk("w0.data", {25'd0, wr_data}, 32'h41);
    chk("w0.ack0", {31'd0, ack0}, 32'd1);
    chk("w0.ack1", {31'd0, ack1}, 32'd0);
    req0 = 1'b0;
    tick();
    chk_idle_outs("w0.after");

    // Ungated instance writes while vblank is low
    vblank = 1'b0;
    b_req1 = 1'b1; b_addr1 = 8'h77; b_code1 = 7'h33;
    tick();
    chk("nb.lat1", {31'd0, b_wr_en}, 32'd0);
    tick();
    chk("nb.wr_en", {31'd0, b_wr_en}, 32'd1);
    chk("nb.addr", {24'd0, b_wr_addr}, 32'h77);
    chk("nb.data", {25'd0, b_wr_data}, 32'h33);
    chk("nb.ack1", {31'd0, b_ack1}, 32'd1);
    b_req1 = 1'b0;

    // Blanking gate: nothing commits while vblank is low
    req1 = 1'b1; addr1 = 8'h5A; code1 = 7'h11;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen = seen | wr_en | ack1;
    end
    chk("gate.hold", {31'd0, seen}, 32'd0);
    vblank = 1'b1;
    tick();
    chk("gate.lat1", {31'd0, wr_en}, 32'd0);
    tick();
    chk("gate.wr_en", {31'd0, wr_en}, 32'd1);
    chk("gate.addr", {24'd0, wr_addr}, 32'h5A);
    chk("gate.data", {25'd0, wr_data}, 32'h11);
    chk("gate.ack1", {31'd0, ack1}, 32'd1);
    req1 = 1'b0;
    tick();
    chk_idle_outs("gate.after");

    // Round robin with both requesters held
    req0 = 1'b1; addr0 = 8'h10; code0 = 7'h01;
    req1 = 1'b1; addr1 = 8'h20; code1 = 7'h02;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr[%0d].acks", i), {30'd0, ack1, ack0}, {30'd0, rr_exp[i]});
      if (rr_exp[i] == 2'b01) chk($sformatf("rr[%0d].addr", i), {24'd0, wr_addr}, 32'h10);
      if (rr_exp[i] == 2'b10) chk($sformatf("rr[%0d].addr", i), {24'd0, wr_addr}, 32'h20);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_idle_outs("rr.after");

    // Full clear in one blanking interval
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr.busy0", {31'd0, clr_busy}, 32'd1);
    chk("clr.wr0", {31'd0, wr_en}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      tick();
      chk($sformatf("clr[%0d].wr_en", i), {31'd0, wr_en}, 32'd1);
      chk($sformatf("clr[%0d].addr", i), {24'd0, wr_addr}, i);
      chk($sformatf("clr[%0d].data", i), {25'd0, wr_data}, 32'h20);
      chk($sformatf("clr[%0d].busy", i), {31'd0, clr_busy}, 32'd1);
      chk($sformatf("clr[%0d].done", i), {31'd0, clr_done}, 32'd0);
    end
    tick();
    chk("clr.end.wr_en", {31'd0, wr_en}, 32'd0);
    chk("clr.end.done", {31'd0, clr_done}, 32'd1);
    chk("clr.end.busy", {31'd0, clr_busy}, 32'd0);
    tick();
    chk("clr.end.done1", {31'd0, clr_done}, 32'd0);

    // Split clear with a request waiting across the gap
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("split[%0d].addr", i), {23'd0, wr_en, wr_addr}, 32'h100 | i);
    end
    vblank = 1'b0;
    req0 = 1'b1; addr0 = 8'hC3; code0 = 7'h5F;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen = seen | wr_en | ack0 | ~clr_busy;
    end
    chk("split.gap", {31'd0, seen}, 32'd0);
    vblank = 1'b1;
    for (int i = 100; i < 256; i++) begin
      tick();
      chk($sformatf("split[%0d].addr", i), {23'd0, wr_en, wr_addr}, 32'h100 | i);
      chk($sformatf("split[%0d].ack0", i), {31'd0, ack0}, 32'd0);
    end
    tick();
    chk("split.done", {31'd0, clr_done}, 32'd1);
    chk("split.ack0_wait", {31'd0, ack0}, 32'd0);
    tick();
    chk("split.req.wr_en", {31'd0, wr_en}, 32'd1);
    chk("split.req.addr", {24'd0, wr_addr}, 32'hC3);
    chk("split.req.data", {25'd0, wr_data}, 32'h5F);
    chk("split.req.ack0", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    tick();
    chk_idle_outs("split.after");

    // Reset in the middle of a clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 57; i++) begin
      tick();
      chk($sformatf("rmid[%0d].addr", i), {23'd0, wr_en, wr_addr}, 32'h100 | i);
    end
    rst = 1'b0;
    #1;
    chk("rmid.busy", {31'd0, clr_busy}, 32'd0);
    chk("rmid.wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rmid.idle.busy", {31'd0, clr_busy}, 32'd0);
    chk("rmid.idle.wr_en", {31'd0, wr_en}, 32'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("rmid.restart.busy", {31'd0, clr_busy}, 32'd1);
    tick();
    chk("rmid.restart.a0", {23'd0, wr_en, wr_addr}, 32'h100);
    tick();
    chk("rmid.restart.a1", {23'd0, wr_en, wr_addr}, 32'h101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_buf_arbiter.md
Name: char_buf_arbiter

Overview:
Owns the write side of the 16x16 character buffer that feeds the text-drawing path (char_xy {row,col} -> 7-bit char code -> font ROM). Arbitrates single-character writes from two requesters (game-status logic, message logic) and sequences a full-screen clear. By default it commits writes only during vertical blanking, so the drawing path never shows a half-updated screen.

Parameters:
BLANK_ONLY, 1, 1: writes and clear steps commit only while vblank=1. 0: commit any cycle.
CLEAR_CODE, 7'h20, character code written to every cell during a clear.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
vblank  in  1  vertical blanking flag from the VGA timing chain, synchronous to clk
clr_req  in  1  clear request, level; sampled when the FSM is in IDLE
clr_busy  out  1  high while a clear is in progress
clr_done  out  1  one-cycle pulse after the final clear write
req0  in  1  requester 0 write request, level
addr0  in  8  requester 0 cell address {row[7:4], col[3:0]}
code0  in  7  requester 0 character code
ack0  out  1  one-cycle pulse in the cycle requester 0's write commits
req1  in  1  requester 1 write request
addr1  in  8  requester 1 cell address
code1  in  7  requester 1 character code
ack1  out  1  one-cycle pulse in the cycle requester 1's write commits
wr_en  out  1  buffer write strobe
wr_addr  out  8  buffer write address
wr_data  out  7  buffer write data

Behaviour:
- All outputs are registered. On reset (rst=0, asynchronous): wr_en=0, wr_addr=0, wr_data=0, ack0=ack1=0, clr_busy=0, clr_done=0, state=IDLE, clear counter=0, rr_last=1 (requester 0 wins first).
- ok = vblank | ~BLANK_ONLY.
- FSM states:
  - IDLE: if clr_req=1, go to CLEAR with counter=0 and clr_busy=1. clr_req has priority over req0/req1 in the same cycle. Otherwise, when ok and any request is pending, go to WRITE.
  - WRITE: one cycle. wr_en=1, wr_addr/wr_data taken from the granted requester, ack of that requester=1, rr_last updated to the granted index. Return to IDLE.
  - CLEAR: in each cycle with ok=1, emit wr_en=1, wr_addr=counter, wr_data=CLEAR_CODE, then increment the counter. In cycles with ok=0, emit wr_en=0 and hold the counter; the clear resumes at the next blanking interval. After the write at counter=255, go to IDLE, clr_busy=0, and pulse clr_done for one cycle. No wrap.
- Arbitration: round-robin. If both requesters are pending, grant the one not equal to rr_last. If only one is pending, grant it.
- Request/data sampling: requests, addresses and codes are sampled on the IDLE->WRITE decision edge. Latency from request to wr_en/ack is 2 cycles. Min spacing between writes is 2 cycles (IDLE/WRITE alternation).
- Requester rules: requesters hold req and their address/code until ack, then drop or change them in the cycle after ack. A req held continuously re-issues.
- Requests arriving during CLEAR wait; no acks are issued during a clear.
- If vblank falls while in WRITE, the already-decided write still completes.
- Reset during a clear aborts it. Buffer contents are undefined; software must reissue clr_req.
- clr_req held high after clr_done starts a new clear.

Test Plan:
- Reset: with rst=0, all outputs are 0. After release, req0=1, addr0=8'h23, code0=7'h41, vblank=1 -> 2 cycles later wr_en=1, wr_addr=8'h23, wr_data=7'h41, ack0=1, each for exactly 1 cycle.
- Blanking gate: req1=1 with vblank=0 for 50 cycles -> no wr_en, no ack1. vblank rises -> write plus ack1 2 cycles later. Same with BLANK_ONLY=0 -> write with no vblank.
- Round robin: req0 and req1 held continuously with vblank=1 -> acks alternate ack0, ack1, ack0, ... one per 2 cycles, starting with ack0 after reset.
- Full clear: clr_req pulse with vblank=1 -> 256 consecutive wr_en with addresses 0..255, data 7'h20. clr_busy is high throughout. clr_done pulses once, in the cycle after the last write.
- Split clear: vblank drops after 100 clear writes, stays low 30 cycles, then rises -> writes resume at address 100 with no duplicates or gaps. req0 raised mid-clear is acked only after clr_done.
- Reset mid-clear: rst low at counter=57 -> clr_busy=0 immediately. After release, IDLE; new clr_req restarts at address 0.
